// File: rtl/pc_sequencer.sv
// Program counter for the Galetron core: increment, relative branch, jump, call/return, context exchange.
// Optional hardware return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int AW           = 12,
    parameter int RESET_VECTOR = 256,
    parameter int CTX_VECTOR   = 1083,
    parameter int RAS_DEPTH    = 4
) (
    input  logic          clock,
    input  logic          resetCPU_n,
    input  logic          HLT,
    input  logic          jump,
    input  logic          call,
    input  logic          ret,
    input  logic          bzero,
    input  logic          bnegative,
    input  logic          zero,
    input  logic          negative,
    input  logic [AW-1:0] address,
    input  logic          jump_context_exchange,
    input  logic          return_context,
    output logic [AW-1:0] programCounter,
    output logic [AW-1:0] saved_pc,
    output logic          in_context,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_error
);

    localparam logic [AW-1:0] L_RST_PC = AW'(RESET_VECTOR);
    localparam logic [AW-1:0] L_CTX_PC = AW'(CTX_VECTOR);
    localparam logic [AW-1:0] L_ONE    = AW'(1);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_saved_pc;
    logic          r_in_ctx;

    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_br_target;
    logic          w_taken;
    logic          w_xchg;
    logic          w_rctx;

    assign w_pc_inc    = r_pc + L_ONE;
    // Offset is two's complement; modulo-2^AW addition handles negative values and wrap.
    assign w_br_target = w_pc_inc + address;
    assign w_taken     = (bzero & zero) | (bnegative & negative);
    assign w_xchg      = jump_context_exchange & ~r_in_ctx;
    assign w_rctx      = return_context & r_in_ctx;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [AW-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0] r_ptr;
    logic          r_err;

    logic [PW-1:0] w_ptr_m1;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_push;

    assign w_ptr_m1 = r_ptr - PW'(1);
    assign w_wr_idx = IW'(r_ptr);
    assign w_rd_idx = IW'(w_ptr_m1);
    assign w_empty  = (r_ptr == '0);
    assign w_full   = (r_ptr == PW'(RAS_DEPTH));
    assign w_push   = ~HLT & ~w_xchg & ~w_rctx & ~ret & call & ~w_full;

    // Stack entries carry no reset; only the pointer defines which ones are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_error = r_err;
`else
    logic w_unused_ret;
    assign w_unused_ret = ret;

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_error = 1'b0;
`endif

    // One action per cycle, highest priority first; lower strobes are dropped.
    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            r_pc       <= L_RST_PC;
            r_saved_pc <= '0;
            r_in_ctx   <= 1'b0;
`ifdef PC_RAS_EN
            r_ptr      <= '0;
            r_err      <= 1'b0;
`endif
        end else if (!HLT) begin
            if (w_xchg) begin
                r_pc       <= L_CTX_PC;
                r_saved_pc <= w_pc_inc;
                r_in_ctx   <= 1'b1;
            end else if (w_rctx) begin
                r_pc     <= r_saved_pc;
                r_in_ctx <= 1'b0;
            end
`ifdef PC_RAS_EN
            else if (ret) begin
                if (!w_empty) begin
                    r_pc  <= r_stack[w_rd_idx];
                    r_ptr <= w_ptr_m1;
                end else begin
                    r_pc  <= w_pc_inc;
                    r_err <= 1'b1;
                end
            end else if (call) begin
                r_pc <= address;
                if (!w_full) begin
                    r_ptr <= r_ptr + PW'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
`endif
            // Without the stack, call degenerates to a plain jump.
            else if (jump | call) begin
                r_pc <= address;
            end else if (w_taken) begin
                r_pc <= w_br_target;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign programCounter = r_pc;
    assign saved_pc       = r_saved_pc;
    assign in_context     = r_in_ctx;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; RAS-specific expectations follow the PC_RAS_EN define.
module tb_pc_sequencer;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          resetCPU_n;
    logic          HLT, jump, call, ret, bzero, bnegative, zero, negative;
    logic [AW-1:0] address;
    logic          jump_context_exchange, return_context;
    logic [AW-1:0] programCounter, saved_pc;
    logic          in_context, ras_empty, ras_full, ras_error;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.AW(AW), .RESET_VECTOR(256), .CTX_VECTOR(1083), .RAS_DEPTH(4)) dut (
        .clock                 (clock),
        .resetCPU_n            (resetCPU_n),
        .HLT                   (HLT),
        .jump                  (jump),
        .call                  (call),
        .ret                   (ret),
        .bzero                 (bzero),
        .bnegative             (bnegative),
        .zero                  (zero),
        .negative              (negative),
        .address               (address),
        .jump_context_exchange (jump_context_exchange),
        .return_context        (return_context),
        .programCounter        (programCounter),
        .saved_pc              (saved_pc),
        .in_context            (in_context),
        .ras_empty             (ras_empty),
        .ras_full              (ras_full),
        .ras_error             (ras_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        HLT = 0; jump = 0; call = 0; ret = 0;
        bzero = 0; bnegative = 0; zero = 0; negative = 0;
        address = '0; jump_context_exchange = 0; return_context = 0;
    endtask

    // Apply current inputs for one edge, sample 1 time unit later, then clear strobes.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_jump(input logic [AW-1:0] a);
        jump = 1; address = a; tick();
    endtask

    initial begin
        idle();
        resetCPU_n = 1'b1;
        #2 resetCPU_n = 1'b0;
        #1;
        check("rst_pc", programCounter, 256);
        check("rst_saved", saved_pc, 0);
        check("rst_inctx", in_context, 0);
        check("rst_empty", ras_empty, 1);
        check("rst_full", ras_full, 0);
        check("rst_err", ras_error, 0);
        #9 resetCPU_n = 1'b1;
        #1;
        check("rel_pc", programCounter, 256);

        tick(); check("inc1", programCounter, 257);
        tick(); check("inc2", programCounter, 258);
        tick(); check("inc3", programCounter, 259);
        HLT = 1; jump = 1; address = 12'd5; tick();
        check("hlt1", programCounter, 259);
        HLT = 1; tick();
        check("hlt2", programCounter, 259);

        do_jump(12'd300); check("jmp300", programCounter, 300);
        bzero = 1; zero = 1; address = 12'hFFE; tick();
        check("bz_taken", programCounter, 299);
        do_jump(12'd300);
        bzero = 1; zero = 0; address = 12'hFFE; tick();
        check("bz_not", programCounter, 301);
        bnegative = 1; negative = 1; address = 12'd5; tick();
        check("bn_taken", programCounter, 307);
        bnegative = 1; negative = 0; bzero = 0; zero = 1; address = 12'd40; tick();
        check("bn_cross", programCounter, 308);
        jump = 1; bzero = 1; zero = 1; address = 12'd77; tick();
        check("jmp_over_br", programCounter, 77);
        do_jump(12'hFFF);
        tick(); check("inc_wrap", programCounter, 0);
        bzero = 1; zero = 1; address = 12'hFFE; tick();
        check("br_wrap", programCounter, 12'hFFF);

        do_jump(12'd10);
        call = 1; address = 12'd500; tick();
        check("call_pc", programCounter, 500);
`ifdef PC_RAS_EN
        check("call_empty", ras_empty, 0);
        ret = 1; tick();
        check("ret_pc", programCounter, 11);
        check("ret_empty", ras_empty, 1);
        check("ret_err0", ras_error, 0);
        ret = 1; jump = 1; address = 12'd77; tick();
        check("ret_empty_pc", programCounter, 12);
        check("ret_empty_err", ras_error, 1);
`else
        check("call_empty", ras_empty, 1);
        ret = 1; tick();
        check("ret_ign_pc", programCounter, 501);
        ret = 1; jump = 1; address = 12'd77; tick();
        check("ret_jmp_pc", programCounter, 77);
        check("noras_empty", ras_empty, 1);
        check("noras_full", ras_full, 0);
        check("noras_err", ras_error, 0);
`endif

        // Asynchronous reset between edges must take effect without a clock.
        #2 resetCPU_n = 1'b0;
        #1;
        check("mid_rst_pc", programCounter, 256);
        check("mid_rst_err", ras_error, 0);
        check("mid_rst_empty", ras_empty, 1);
        #1 resetCPU_n = 1'b1;
        tick(); check("post_rst_pc", programCounter, 257);

`ifdef PC_RAS_EN
        do_jump(12'd100);
        call = 1; address = 12'd200; tick();
        call = 1; address = 12'd300; tick();
        HLT = 1; call = 1; address = 12'd999; tick();
        check("hlt_call_pc", programCounter, 300);
        call = 1; address = 12'd400; tick();
        check("ras_notfull", ras_full, 0);
        call = 1; address = 12'd500; tick();
        check("ras_full", ras_full, 1);
        check("ras_err_pre", ras_error, 0);
        call = 1; address = 12'd900; tick();
        check("call_full_pc", programCounter, 900);
        check("call_full_flag", ras_full, 1);
        check("call_full_err", ras_error, 1);
        ret = 1; tick(); check("lifo1", programCounter, 401);
        ret = 1; tick(); check("lifo2", programCounter, 301);
        ret = 1; tick(); check("lifo3", programCounter, 201);
        ret = 1; tick(); check("lifo4", programCounter, 101);
        check("lifo_empty", ras_empty, 1);
        check("err_sticky", ras_error, 1);
`endif

        do_jump(12'd600);
        jump_context_exchange = 1; return_context = 1; tick();
        check("xchg_pc", programCounter, 1083);
        check("xchg_saved", saved_pc, 601);
        check("xchg_inctx", in_context, 1);
        jump_context_exchange = 1; jump = 1; address = 12'd50; tick();
        check("xchg2_pc", programCounter, 50);
        check("xchg2_saved", saved_pc, 601);
        HLT = 1; return_context = 1; tick();
        check("hlt_rctx_pc", programCounter, 50);
        check("hlt_rctx_inctx", in_context, 1);
        return_context = 1; jump = 1; address = 12'd9; tick();
        check("rctx_pc", programCounter, 601);
        check("rctx_inctx", in_context, 0);
        return_context = 1; tick();
        check("rctx_ign_pc", programCounter, 602);
        check("rctx_ign_saved", saved_pc, 601);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
